// File: rtl/rtc_bus_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : rtc_bus_pkg
// Brief    : State encoding, timing defaults and RTC register map for rtc_bus_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rtc_bus_pkg;

  localparam logic [3:0] ST_POR     = 4'd0;
  localparam logic [3:0] ST_IDLE    = 4'd1;
  localparam logic [3:0] ST_A_SETUP = 4'd2;
  localparam logic [3:0] ST_A_PULSE = 4'd3;
  localparam logic [3:0] ST_A_HOLD  = 4'd4;
  localparam logic [3:0] ST_GAP     = 4'd5;
  localparam logic [3:0] ST_D_SETUP = 4'd6;
  localparam logic [3:0] ST_D_PULSE = 4'd7;
  localparam logic [3:0] ST_D_HOLD  = 4'd8;
  localparam logic [3:0] ST_DONE    = 4'd9;

  typedef enum logic [3:0] {
    S_POR     = ST_POR,
    S_IDLE    = ST_IDLE,
    S_A_SETUP = ST_A_SETUP,
    S_A_PULSE = ST_A_PULSE,
    S_A_HOLD  = ST_A_HOLD,
    S_GAP     = ST_GAP,
    S_D_SETUP = ST_D_SETUP,
    S_D_PULSE = ST_D_PULSE,
    S_D_HOLD  = ST_D_HOLD,
    S_DONE    = ST_DONE
  } state_t;

  localparam int DEF_T_SETUP    = 2;
  localparam int DEF_T_PULSE    = 8;
  localparam int DEF_T_HOLD     = 2;
  localparam int DEF_T_GAP      = 4;
  localparam int DEF_POR_CYCLES = 16;

  localparam logic [7:0] INIT_ADDR = 8'h02;
  localparam logic [7:0] INIT_DATA = 8'h10;

  localparam logic [7:0] REG_SEC     = 8'h21;
  localparam logic [7:0] REG_MIN     = 8'h22;
  localparam logic [7:0] REG_HOUR    = 8'h23;
  localparam logic [7:0] REG_DAY     = 8'h24;
  localparam logic [7:0] REG_MONTH   = 8'h25;
  localparam logic [7:0] REG_YEAR    = 8'h26;
  localparam logic [7:0] REG_WEEKDAY = 8'h27;
  localparam logic [7:0] REG_TMR_SEC  = 8'h41;
  localparam logic [7:0] REG_TMR_MIN  = 8'h42;
  localparam logic [7:0] REG_TMR_HOUR = 8'h43;
  localparam logic [7:0] REG_TMR_CTRL = 8'h44;
  localparam logic [7:0] CMD_TRANSFER = 8'hF0;

  // Counter runs down to zero, so a state lasting N cycles reloads with N-1.
  function automatic logic [7:0] phase_reload(input int unsigned cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_bus_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : rtc_bus_ctrl_if
// Brief    : Menu-FSM request handshake plus RTC multiplexed bus signals.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rtc_bus_ctrl_if;
  logic       acceso;
  logic       mod;
  logic [6:0] dir;
  logic [7:0] wdata;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] rdata;
  logic       frw;
  logic       busy;

  modport master (
    output acceso, mod, dir, wdata, ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rdata, frw, busy
  );

  modport slave (
    input  acceso, mod, dir, wdata, ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, rdata, frw, busy
  );
endinterface

`default_nettype wire

// File: rtl/rtc_bus_ctrl_phase_timer.sv
//------------------------------------------------------------------------------
// Module   : rtc_phase_timer
// Brief    : 8-bit loadable down-counter; done while the count sits at zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rtc_phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign done = (r_cnt == 8'd0);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_ctrl.sv
//------------------------------------------------------------------------------
// Module   : rtc_bus_ctrl
// Brief    : Runs address+data transactions on the RTC multiplexed bus for the menu FSM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP    = DEF_T_SETUP,
  parameter int T_PULSE    = DEF_T_PULSE,
  parameter int T_HOLD     = DEF_T_HOLD,
  parameter int T_GAP      = DEF_T_GAP,
  parameter int POR_CYCLES = DEF_POR_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  rtc_bus_ctrl_if.slave bus
);

  state_t      r_state, w_next;
  logic        r_acceso_d, w_req;
  logic        r_pending, w_start_pend, w_take_req, w_queue_req;
  logic [7:0]  r_pend_addr, r_pend_data;
  logic        r_pend_mod;
  logic [7:0]  r_cur_addr, r_cur_data, w_cur_addr, w_cur_data;
  logic        r_cur_mod, w_cur_mod;
  logic        w_timer_done, w_load;
  int unsigned w_len;
  logic        w_cs_n, w_wr_n, w_rd_n, w_a_d, w_oe, w_frw;
  logic [7:0]  w_ad_out;
  logic        r_cs_n, r_wr_n, r_rd_n, r_a_d, r_oe, r_frw, r_busy;
  logic [7:0]  r_ad_out, r_rdata;

  assign w_req        = bus.acceso & ~r_acceso_d;
  assign w_start_pend = r_pending && (r_state == S_IDLE || r_state == S_DONE);
  assign w_take_req   = w_req && !r_pending && (r_state == S_IDLE);
  assign w_queue_req  = w_req && !r_pending && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_POR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_POR:     if (w_timer_done) w_next = S_A_SETUP;
      S_IDLE:    if (r_pending || w_req) w_next = S_A_SETUP;
      S_A_SETUP: if (w_timer_done) w_next = S_A_PULSE;
      S_A_PULSE: if (w_timer_done) w_next = S_A_HOLD;
      S_A_HOLD:  if (w_timer_done) w_next = S_GAP;
      S_GAP:     if (w_timer_done) w_next = S_D_SETUP;
      S_D_SETUP: if (w_timer_done) w_next = S_D_PULSE;
      S_D_PULSE: if (w_timer_done) w_next = S_D_HOLD;
      S_D_HOLD:  if (w_timer_done) w_next = S_DONE;
      S_DONE:    w_next = r_pending ? S_A_SETUP : S_IDLE;
      default:   w_next = S_POR;
    endcase
  end

  // Transaction operands for the state being entered; outputs are registered from these.
  always_comb begin
    w_cur_addr = r_cur_addr;
    w_cur_data = r_cur_data;
    w_cur_mod  = r_cur_mod;
    if (r_state == S_POR && w_timer_done) begin
      w_cur_addr = INIT_ADDR;
      w_cur_data = INIT_DATA;
      w_cur_mod  = 1'b1;
    end else if (w_start_pend) begin
      w_cur_addr = r_pend_addr;
      w_cur_data = r_pend_data;
      w_cur_mod  = r_pend_mod;
    end else if (w_take_req) begin
      w_cur_addr = {1'b0, bus.dir};
      w_cur_data = bus.wdata;
      w_cur_mod  = bus.mod;
    end
  end

  always_comb begin
    w_cs_n   = 1'b1;
    w_wr_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_a_d    = 1'b0;
    w_oe     = 1'b0;
    w_frw    = 1'b0;
    w_ad_out = 8'h00;
    case (w_next)
      S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
        w_cs_n   = 1'b0;
        w_oe     = 1'b1;
        w_ad_out = w_cur_addr;
        w_wr_n   = (w_next != S_A_PULSE);
      end
      S_D_SETUP, S_D_PULSE, S_D_HOLD: begin
        w_cs_n   = 1'b0;
        w_a_d    = 1'b1;
        w_oe     = w_cur_mod;
        w_ad_out = w_cur_data;
        if (w_next == S_D_PULSE) begin
          w_wr_n = ~w_cur_mod;
          w_rd_n = w_cur_mod;
        end
      end
      S_DONE:  w_frw = 1'b1;
      default: w_frw = 1'b0;
    endcase
  end

  always_comb begin
    w_len = 1;
    case (w_next)
      S_POR:                w_len = POR_CYCLES;
      S_A_SETUP, S_D_SETUP: w_len = T_SETUP;
      S_A_PULSE, S_D_PULSE: w_len = T_PULSE;
      S_A_HOLD,  S_D_HOLD:  w_len = T_HOLD;
      S_GAP:                w_len = T_GAP;
      default:              w_len = 1;
    endcase
  end

  assign w_load = (w_next != r_state);

  rtc_phase_timer #(
    .RST_VAL (phase_reload(POR_CYCLES))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (phase_reload(w_len)),
    .done     (w_timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acceso_d  <= 1'b1;
      r_pending   <= 1'b0;
      r_pend_addr <= 8'h00;
      r_pend_data <= 8'h00;
      r_pend_mod  <= 1'b0;
      r_cur_addr  <= 8'h00;
      r_cur_data  <= 8'h00;
      r_cur_mod   <= 1'b0;
      r_cs_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_a_d       <= 1'b0;
      r_oe        <= 1'b0;
      r_ad_out    <= 8'h00;
      r_frw       <= 1'b0;
      r_busy      <= 1'b1;
      r_rdata     <= 8'h00;
    end else begin
      r_acceso_d <= bus.acceso;
      if (w_start_pend) begin
        r_pending <= 1'b0;
      end else if (w_queue_req) begin
        r_pending   <= 1'b1;
        r_pend_addr <= {1'b0, bus.dir};
        r_pend_data <= bus.wdata;
        r_pend_mod  <= bus.mod;
      end
      r_cur_addr <= w_cur_addr;
      r_cur_data <= w_cur_data;
      r_cur_mod  <= w_cur_mod;
      r_cs_n     <= w_cs_n;
      r_wr_n     <= w_wr_n;
      r_rd_n     <= w_rd_n;
      r_a_d      <= w_a_d;
      r_oe       <= w_oe;
      r_ad_out   <= w_ad_out;
      r_frw      <= w_frw;
      r_busy     <= (w_next != S_IDLE);
      if (r_state == S_D_PULSE && w_timer_done && !r_cur_mod) begin
        r_rdata <= bus.ad_in;
      end
    end
  end

  assign bus.cs_n   = r_cs_n;
  assign bus.wr_n   = r_wr_n;
  assign bus.rd_n   = r_rd_n;
  assign bus.a_d    = r_a_d;
  assign bus.ad_oe  = r_oe;
  assign bus.ad_out = r_ad_out;
  assign bus.frw    = r_frw;
  assign bus.busy   = r_busy;
  assign bus.rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_rtc_bus_ctrl
// Brief    : Self-checking bench for rtc_bus_ctrl against a cycle-offset bus model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rtc_bus_ctrl;

  localparam int S = 2, P = 8, H = 2, G = 4, POR_N = 16;
  localparam int TXN  = 2 * (S + P + H) + G;          // offset of DONE from A_SETUP entry
  localparam int RD_K = 2 * S + 2 * P + H + G - 1;    // last data-phase strobe cycle
  localparam logic [14:0] POR_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

  logic clk = 1'b0;
  logic rst_n;
  rtc_bus_ctrl_if bif();

  rtc_bus_ctrl #(
    .T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_GAP(G), .POR_CYCLES(POR_N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frw_seen = 0;
  logic prev_frw = 1'b0;
  logic [7:0] exp_rdata = 8'h00;

  // {cs_n, wr_n, rd_n, a_d (only meaningful while selected), ad_oe, frw, busy, driven byte}
  logic [14:0] obs;
  assign obs = {bif.cs_n, bif.wr_n, bif.rd_n, bif.a_d & ~bif.cs_n, bif.ad_oe,
                bif.frw, bif.busy, bif.ad_oe ? bif.ad_out : 8'h00};

  // Expected bus at offset k from A_SETUP entry; outside 0..TXN the block is idle.
  function automatic logic [14:0] model_bus(input int k, input logic [7:0] addr,
                                            input logic [7:0] data, input logic wr);
    logic cs_n, wr_n, rd_n, a_d, oe, frw, busy;
    logic [7:0] val;
    int j;
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; a_d = 1'b0; oe = 1'b0;
    frw = 1'b0; busy = 1'b1; val = 8'h00;
    if (k < 0 || k > TXN) begin
      busy = 1'b0;
    end else if (k < S + P + H) begin
      cs_n = 1'b0; oe = 1'b1; val = addr;
      wr_n = !(k >= S && k < S + P);
    end else if (k < S + P + H + G) begin
      cs_n = 1'b1;
    end else if (k < TXN) begin
      j = k - (S + P + H + G);
      cs_n = 1'b0; a_d = 1'b1; oe = wr; val = wr ? data : 8'h00;
      if (j >= S && j < S + P) begin
        if (wr) wr_n = 1'b0;
        else    rd_n = 1'b0;
      end
    end else begin
      frw = 1'b1;
    end
    return {cs_n, wr_n, rd_n, a_d, oe, frw, busy, val};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks += 3;
      if (!bif.rd_n && !bif.wr_n) begin
        n_fail++;
        $display("FAIL strobe_overlap: rd_n=%b wr_n=%b, required not both low", bif.rd_n, bif.wr_n);
      end
      if ((!bif.rd_n || !bif.wr_n) && bif.cs_n) begin
        n_fail++;
        $display("FAIL strobe_unselected: rd_n=%b wr_n=%b cs_n=%b, required no strobe with cs_n=1",
                 bif.rd_n, bif.wr_n, bif.cs_n);
      end
      if (bif.frw && prev_frw) begin
        n_fail++;
        $display("FAIL frw_width: frw high two cycles running, required single-cycle pulse");
      end
    end
    if (bif.frw) frw_seen++;
    prev_frw = bif.frw;
  end

  task automatic test_reset(input logic acc);
    bif.acceso = acc; bif.mod = 1'b0; bif.dir = 7'h00; bif.wdata = 8'h00; bif.ad_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bif.cs_n, bif.rd_n, bif.wr_n, bif.a_d, bif.ad_oe, bif.ad_out, bif.rdata, bif.frw, bif.busy}
        !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got cs_n=%b rd_n=%b wr_n=%b a_d=%b oe=%b ad_out=%h rdata=%h frw=%b busy=%b, required 1 1 1 0 0 00 00 0 1",
               bif.cs_n, bif.rd_n, bif.wr_n, bif.a_d, bif.ad_oe, bif.ad_out, bif.rdata, bif.frw, bif.busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 8'h00;
  endtask

  // Called at the negedge where reset was released (POR cycle 0).
  task automatic test_init();
    int f0;
    logic [14:0] exp;
    f0 = frw_seen;
    for (int c = 0; c < POR_N; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (obs !== POR_VEC) begin
        n_fail++;
        $display("FAIL por_idle c=%0d: got %h, required %h", c, obs, POR_VEC);
      end
    end
    for (int k = 0; k <= TXN + 1; k++) begin
      @(negedge clk);
      exp = model_bus(k, 8'h02, 8'h10, 1'b1);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL init_bus k=%0d: got %h, required %h", k, obs, exp);
      end
    end
    n_checks++;
    if (frw_seen - f0 !== 1 || bif.rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL init_frw: frw pulses=%0d rdata=%h, required 1 and %h", frw_seen - f0, bif.rdata, exp_rdata);
    end
  endtask

  // Starts at an idle negedge with acceso low; ends at the idle cycle after DONE.
  task automatic test_txn(input logic [6:0] addr, input logic [7:0] data, input logic wr,
                          input logic [7:0] rd_val);
    logic [14:0] exp;
    bif.dir = addr; bif.wdata = data; bif.mod = wr; bif.acceso = 1'b1; bif.ad_in = ~rd_val;
    for (int k = 0; k <= TXN + 1; k++) begin
      @(negedge clk);
      exp = model_bus(k, {1'b0, addr}, data, wr);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL txn_bus a=%h d=%h wr=%b k=%0d: got %h, required %h", addr, data, wr, k, obs, exp);
      end
      if (k == 0) begin
        bif.acceso = 1'b0;
        bif.dir = 7'($urandom); bif.wdata = 8'($urandom); bif.mod = 1'($urandom);
      end
      bif.ad_in = (k == RD_K) ? rd_val : ~rd_val;
      if (k == TXN) begin
        if (!wr) exp_rdata = rd_val;
        n_checks++;
        if (bif.rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL txn_rdata a=%h wr=%b: got %h, required %h", addr, wr, bif.rdata, exp_rdata);
        end
      end
    end
  endtask

  task automatic test_write();
    test_txn(7'h21, 8'h59, 1'b1, 8'($urandom));
  endtask

  task automatic test_read();
    test_txn(7'h44, 8'($urandom), 1'b0, 8'h23);
    test_txn(7'h22, 8'hA5, 1'b1, 8'h77);
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== model_bus(-1, 8'h00, 8'h00, 1'b0)) begin
          n_fail++;
          $display("FAIL idle_bus i=%0d: got %h, required %h", i, obs, model_bus(-1, 8'h00, 8'h00, 1'b0));
        end
      end
      test_txn(7'($urandom_range(0, 127)), 8'($urandom), 1'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a1, a2, a3;
    logic [7:0] d1, d2, d3, rd;
    logic [14:0] exp;
    int f0;
    a1 = 7'($urandom); a2 = 7'($urandom); a3 = 7'($urandom);
    d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom); rd = 8'($urandom);
    f0 = frw_seen;
    bif.dir = a1; bif.wdata = d1; bif.mod = 1'b1; bif.acceso = 1'b1; bif.ad_in = ~rd;
    for (int k = 0; k <= 2 * (TXN + 1); k++) begin
      @(negedge clk);
      exp = (k <= TXN) ? model_bus(k, {1'b0, a1}, d1, 1'b1)
                       : model_bus(k - TXN - 1, {1'b0, a2}, d2, 1'b0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b_bus k=%0d: got %h, required %h", k, obs, exp);
      end
      case (k)
        0, 6, 12: bif.acceso = 1'b0;
        4:  begin bif.dir = a2; bif.wdata = d2; bif.mod = 1'b0; bif.acceso = 1'b1; end
        10: begin bif.dir = a3; bif.wdata = d3; bif.mod = 1'b1; bif.acceso = 1'b1; end
        default: ;
      endcase
      bif.ad_in = (k == TXN + 1 + RD_K) ? rd : ~rd;
    end
    exp_rdata = rd;
    n_checks++;
    if (bif.rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL b2b_rdata: got %h, required %h", bif.rdata, exp_rdata);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (frw_seen - f0 !== 2 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: frw pulses=%0d busy=%b, required 2 and 0", frw_seen - f0, bif.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] a;
    logic [7:0] d;
    logic [14:0] exp;
    int f0;
    a = 7'($urandom); d = 8'($urandom);
    f0 = frw_seen;
    bif.dir = a; bif.wdata = d; bif.mod = 1'b1; bif.acceso = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      exp = model_bus(k, {1'b0, a}, d, 1'b1);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rstmid_bus k=%0d: got %h, required %h", k, obs, exp);
      end
      if (k == 0) bif.acceso = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bif.cs_n, bif.wr_n, bif.rd_n, bif.ad_oe, bif.frw, bif.busy} !== 6'b111001) begin
      n_fail++;
      $display("FAIL rstmid_release: got cs_n=%b wr_n=%b rd_n=%b oe=%b frw=%b busy=%b, required 1 1 1 0 0 1",
               bif.cs_n, bif.wr_n, bif.rd_n, bif.ad_oe, bif.frw, bif.busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 8'h00;
    n_checks++;
    if (frw_seen !== f0) begin
      n_fail++;
      $display("FAIL rstmid_frw: frw pulses=%0d, required 0", frw_seen - f0);
    end
    test_init();
  endtask

  task automatic test_acceso_held();
    int f0;
    test_reset(1'b1);
    test_init();
    f0 = frw_seen;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_bus(-1, 8'h00, 8'h00, 1'b0)) begin
        n_fail++;
        $display("FAIL held_idle c=%0d: got %h, required %h", c, obs, model_bus(-1, 8'h00, 8'h00, 1'b0));
      end
    end
    n_checks++;
    if (frw_seen !== f0) begin
      n_fail++;
      $display("FAIL held_frw: frw pulses=%0d, required 0", frw_seen - f0);
    end
    bif.acceso = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.acceso = 1'b0; bif.mod = 1'b0; bif.dir = 7'h00; bif.wdata = 8'h00; bif.ad_in = 8'h00;
    test_reset(1'b0);
    test_init();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_acceso_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
